// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl
//
// Sequencer that sits directly in front of the SIMON 2-share key schedule.
// It collects a serial plaintext block and then a serial key over a simple
// valid/ready handshake, forwards each accepted bit to the schedule with the
// matching data_rdy code, then steps the schedule through the round phase
// and pulses done once the last round cycle has been issued.
//
// Optional feature macro: SIMON_CTRL_ABORT_EN
//   When defined, an extra 'abort' input cancels a load or run in progress.
//   When undefined, an operation ends only through DONE or rst.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin an operation (only looked at in IDLE)
//   din_valid  in   1  serial bit valid
//   din        in   1  serial bit: plaintext first, then key {KX,KY}, KY LSB first
//   abort      in   1  (SIMON_CTRL_ABORT_EN only) cancel the current operation
//   din_ready  out  1  high while a plaintext or key bit can be accepted
//   data_in    out  1  bit to the key schedule, din on a transfer else 0
//   data_rdy   out  2  0 idle/stall, 1 plaintext shift, 2 key shift, 3 run
//   counter    out  8  round-phase count; the schedule updates when counter[0]=1
//   busy       out  1  high in every state except IDLE
//   done       out  1  one-cycle pulse after the final round cycle

module simon_seq_ctrl #(
  parameter int BLOCK_BITS  = 128,
  parameter int KEY_BITS    = 128,
  parameter int ROUNDS      = 68,
  parameter int CYC_PER_RND = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din_valid,
  input  logic       din,
`ifdef SIMON_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       din_ready,
  output logic       data_in,
  output logic [1:0] data_rdy,
  output logic [7:0] counter,
  output logic       busy,
  output logic       done
);

  localparam int MAX_BITS   = (BLOCK_BITS > KEY_BITS) ? BLOCK_BITS : KEY_BITS;
  localparam int CNT_W      = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int RUN_CYCLES = ROUNDS * CYC_PER_RND;

  localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(BLOCK_BITS - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
  localparam logic [7:0]       RUN_LAST = 8'(RUN_CYCLES - 1);

  // The round-phase count is only 8 bits wide, so the run must fit in it.
  if (RUN_CYCLES > 256 || RUN_CYCLES < 1) begin : g_bad_cfg
    $error("simon_seq_ctrl: ROUNDS*CYC_PER_RND must be in 1..256");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_PT  = 3'd1,
    LOAD_KEY = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       next_counter;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] next_bit_cnt;
  logic             transfer;
  logic             abort_hit;

  // An abort only matters while an operation is actually loading or running;
  // in IDLE and DONE it is ignored.
`ifdef SIMON_CTRL_ABORT_EN
  assign abort_hit = abort &&
                     ((state == LOAD_PT) || (state == LOAD_KEY) || (state == RUN));
`else
  assign abort_hit = 1'b0;
`endif

  // State, round-phase counter and bit counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
      bit_cnt <= next_bit_cnt;
    end
  end

  // Next-state and output decode. data_rdy during a load depends on the
  // handshake in the same cycle, so a stalled cycle (din_valid=0) presents
  // code 0 and the key schedule simply holds its contents.
  always_comb begin
    next_state   = state;
    next_counter = counter;
    next_bit_cnt = bit_cnt;
    din_ready    = 1'b0;
    data_rdy     = 2'd0;
    data_in      = 1'b0;
    transfer     = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          next_state   = LOAD_PT;
          next_bit_cnt = '0;
          next_counter = '0;
        end
      end

      LOAD_PT: begin
        din_ready = 1'b1;
        transfer  = din_valid;
        if (transfer) begin
          data_rdy = 2'd1;
          data_in  = din;
          if (bit_cnt == PT_LAST) begin
            next_state   = LOAD_KEY;
            next_bit_cnt = '0;
          end else begin
            next_bit_cnt = bit_cnt + 1'b1;
          end
        end
      end

      LOAD_KEY: begin
        din_ready = 1'b1;
        transfer  = din_valid;
        if (transfer) begin
          data_rdy = 2'd2;
          data_in  = din;
          if (bit_cnt == KEY_LAST) begin
            next_state   = RUN;
            next_bit_cnt = '0;
            next_counter = '0;
          end else begin
            next_bit_cnt = bit_cnt + 1'b1;
          end
        end
      end

      // The counter is left at its terminal value on the way to DONE so the
      // schedule (and anyone watching) sees where the run ended.
      RUN: begin
        data_rdy = 2'd3;
        if (counter == RUN_LAST) begin
          next_state = DONE;
        end else begin
          next_counter = counter + 8'd1;
        end
      end

      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    // Abort wins over whatever the state would otherwise do, including a
    // terminal transfer or the last round cycle, and suppresses done.
    if (abort_hit) begin
      next_state   = IDLE;
      next_counter = '0;
      next_bit_cnt = '0;
      din_ready    = 1'b0;
      data_rdy     = 2'd0;
      data_in      = 1'b0;
      transfer     = 1'b0;
    end
  end

endmodule
